// File: rtl/vga_fb_pkg.sv
// Shared definitions for the VGA frame-buffer arbiter.
// - bus_op_t: SRAM bus operation driven in the current cycle.
// - fb_words(): words per frame buffer.
// - buf_base(): first SRAM word address of a given buffer.
package vga_fb_pkg;

    typedef enum logic [1:0] {
        BusIdle  = 2'd0,
        BusRead  = 2'd1,
        BusTurn  = 2'd2,
        BusWrite = 2'd3
    } bus_op_t;

    function automatic int unsigned fb_words(input int unsigned h_visible,
                                             input int unsigned v_visible);
        return h_visible * v_visible;
    endfunction

    function automatic int unsigned buf_base(input logic        sel,
                                             input int unsigned h_visible,
                                             input int unsigned v_visible);
        return sel ? fb_words(h_visible, v_visible) : 32'd0;
    endfunction

endpackage

// File: rtl/vga_fb_delay.sv
// Fixed-latency shift register used to align the sync signals with the
// registered pixel data.
// Ports:
//   clk_i  - clock
//   rst_i  - asynchronous active-high reset, clears every stage
//   d_i    - input word
//   q_o    - input word delayed by STAGES cycles
module vga_fb_delay #(
    parameter int unsigned STAGES = 2,
    parameter int unsigned WIDTH  = 3
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Arbitrates one single-port async SRAM between the VGA display read path
// and a back-buffer pixel writer, and manages front/back buffer swapping.
// Ports:
//   clk, reset                 - clock, asynchronous active-high reset
//   disp_*                     - timing from vga_sync (visible, syncs, column, row)
//   pix_data, pix_visible,
//   pix_hsync, pix_vsync       - pixel word and syncs, 2 cycles after disp_*
//   wr_valid/wr_ready,
//   wr_addr, wr_data           - back-buffer write handshake (buffer-relative address)
//   swap_req, swap_done,
//   front_sel                  - swap request pulse, swap-applied pulse, front buffer index
//   sram_*                     - external SRAM address, data and active-low strobes
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 20,
    parameter int unsigned DATA_BITS   = 16,
    parameter int unsigned COLUMN_BITS = 10,
    parameter int unsigned ROW_BITS    = 10,
    parameter int unsigned H_VISIBLE   = 640,
    parameter int unsigned V_VISIBLE   = 480
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   disp_visible,
    input  logic                   disp_hsync,
    input  logic                   disp_vsync,
    input  logic [COLUMN_BITS-1:0] disp_column,
    input  logic [ROW_BITS-1:0]    disp_row,
    output logic [DATA_BITS-1:0]   pix_data,
    output logic                   pix_visible,
    output logic                   pix_hsync,
    output logic                   pix_vsync,
    input  logic                   wr_valid,
    output logic                   wr_ready,
    input  logic [ADDR_BITS-1:0]   wr_addr,
    input  logic [DATA_BITS-1:0]   wr_data,
    input  logic                   swap_req,
    output logic                   swap_done,
    output logic                   front_sel,
    output logic [ADDR_BITS-1:0]   sram_addr,
    output logic [DATA_BITS-1:0]   sram_data_out,
    input  logic [DATA_BITS-1:0]   sram_data_in,
    output logic                   sram_data_oe,
    output logic                   sram_we_n,
    output logic                   sram_oe_n
);

    bus_op_t               state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_BITS-1:0]  wdata_q, wdata_d;
    logic [DATA_BITS-1:0]  pix_data_q, pix_data_d;
    logic                  front_sel_q, front_sel_d;
    logic                  swap_pending_q, swap_pending_d;
    logic                  swap_done_q, swap_done_d;

    logic [ADDR_BITS-1:0]  front_base, back_base, rd_addr, wr_addr_full;
    logic                  wr_accept, swap_point;
    logic [2:0]            sync_dly;

    // Buffer bases follow the registered front_sel, so a write accepted on the
    // swap-point cycle still targets the pre-swap back buffer.
    assign front_base   = ADDR_BITS'(buf_base(front_sel_q, H_VISIBLE, V_VISIBLE));
    assign back_base    = ADDR_BITS'(buf_base(!front_sel_q, H_VISIBLE, V_VISIBLE));
    assign rd_addr      = front_base + ADDR_BITS'(disp_row) * ADDR_BITS'(H_VISIBLE)
                        + ADDR_BITS'(disp_column);
    assign wr_addr_full = back_base + wr_addr;

    // Blocking writes on the cycle after a read forces a TURN/IDLE gap so the
    // SRAM releases the data bus before the FPGA drives it.
    assign wr_ready  = !disp_visible && (state_q != BusRead) && !reset;
    assign wr_accept = wr_valid && wr_ready;

    assign swap_point = (disp_row == ROW_BITS'(V_VISIBLE)) && (disp_column == '0);

    // Bus FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= BusIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Bus FSM: next-state decision, display first
    always_comb begin
        state_d = BusIdle;
        if (disp_visible) begin
            state_d = BusRead;
        end else if (wr_accept) begin
            state_d = BusWrite;
        end else if (wr_valid && (state_q == BusRead)) begin
            state_d = BusTurn;
        end
    end

    // Bus FSM: strobes decoded from the registered op; reset clears them at once
    always_comb begin
        sram_oe_n    = (state_q != BusRead);
        sram_we_n    = (state_q != BusWrite);
        sram_data_oe = (state_q == BusWrite);
    end

    // Address/data launched together with the op; held during IDLE/TURN
    always_comb begin
        addr_d  = addr_q;
        wdata_d = wdata_q;
        unique case (state_d)
            BusRead:  addr_d = rd_addr;
            BusWrite: begin
                addr_d  = wr_addr_full;
                wdata_d = wr_data;
            end
            default: ;
        endcase
    end

    // Capture the SRAM word at the end of the read cycle; blank otherwise
    assign pix_data_d = (state_q == BusRead) ? sram_data_in : '0;

    always_comb begin
        front_sel_d    = front_sel_q;
        swap_pending_d = swap_pending_q;
        swap_done_d    = 1'b0;
        if (swap_point && (swap_pending_q || swap_req)) begin
            front_sel_d    = !front_sel_q;
            swap_pending_d = 1'b0;
            swap_done_d    = 1'b1;
        end else if (swap_req) begin
            swap_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_q         <= '0;
            wdata_q        <= '0;
            pix_data_q     <= '0;
            front_sel_q    <= 1'b0;
            swap_pending_q <= 1'b0;
            swap_done_q    <= 1'b0;
        end else begin
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            pix_data_q     <= pix_data_d;
            front_sel_q    <= front_sel_d;
            swap_pending_q <= swap_pending_d;
            swap_done_q    <= swap_done_d;
        end
    end

    vga_fb_delay #(
        .STAGES (2),
        .WIDTH  (3)
    ) u_sync_delay (
        .clk_i (clk),
        .rst_i (reset),
        .d_i   ({disp_visible, disp_hsync, disp_vsync}),
        .q_o   (sync_dly)
    );

    assign pix_visible   = sync_dly[2];
    assign pix_hsync     = sync_dly[1];
    assign pix_vsync     = sync_dly[0];
    assign pix_data      = pix_data_q;
    assign sram_addr     = addr_q;
    assign sram_data_out = wdata_q;
    assign front_sel     = front_sel_q;
    assign swap_done     = swap_done_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter: table-driven read/write address vectors
// plus hand-written sequences for turnaround, swap and reset corner cases.
module tb_vga_fb_arbiter;

    localparam int unsigned FB = 307200;

    logic        clk = 1'b0;
    logic        reset;
    logic        disp_visible, disp_hsync, disp_vsync;
    logic [9:0]  disp_column, disp_row;
    logic [15:0] pix_data;
    logic        pix_visible, pix_hsync, pix_vsync;
    logic        wr_valid, wr_ready;
    logic [19:0] wr_addr;
    logic [15:0] wr_data;
    logic        swap_req, swap_done, front_sel;
    logic [19:0] sram_addr;
    logic [15:0] sram_data_out, sram_data_in;
    logic        sram_data_oe, sram_we_n, sram_oe_n;

    logic        din_ovr_en;
    logic [15:0] din_ovr;

    int n_checks = 0;
    int n_pass   = 0;
    int viol     = 0;
    logic prev_rd = 1'b0;

    typedef struct {
        logic [9:0]  row;
        logic [9:0]  col;
        logic [19:0] exp_addr;
    } rd_vec_t;

    typedef struct {
        logic [19:0] waddr;
        logic [15:0] wdata;
        logic [19:0] exp_addr;
    } wr_vec_t;

    rd_vec_t rd_tab[6];
    wr_vec_t wr_tab[3];

    always #5 clk = ~clk;

    // SRAM stand-in: returns an address-derived word while oe_n is low
    assign sram_data_in = din_ovr_en ? din_ovr
                        : (sram_oe_n ? 16'h0000 : (sram_addr[15:0] ^ 16'h5A5A));

    vga_fb_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .disp_visible  (disp_visible),
        .disp_hsync    (disp_hsync),
        .disp_vsync    (disp_vsync),
        .disp_column   (disp_column),
        .disp_row      (disp_row),
        .pix_data      (pix_data),
        .pix_visible   (pix_visible),
        .pix_hsync     (pix_hsync),
        .pix_vsync     (pix_vsync),
        .wr_valid      (wr_valid),
        .wr_ready      (wr_ready),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .swap_req      (swap_req),
        .swap_done     (swap_done),
        .front_sel     (front_sel),
        .sram_addr     (sram_addr),
        .sram_data_out (sram_data_out),
        .sram_data_in  (sram_data_in),
        .sram_data_oe  (sram_data_oe),
        .sram_we_n     (sram_we_n),
        .sram_oe_n     (sram_oe_n)
    );

    // Watch every cycle for a WRITE directly after a READ
    always @(negedge clk) begin
        if (reset) begin
            prev_rd = 1'b0;
        end else begin
            if (prev_rd && !sram_we_n) viol++;
            prev_rd = !sram_oe_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_we_n"},     32'(sram_we_n), 32'd1);
        chk({tag, "_oe_n"},     32'(sram_oe_n), 32'd1);
        chk({tag, "_data_oe"},  32'(sram_data_oe), 32'd0);
        chk({tag, "_addr"},     32'(sram_addr), 32'd0);
        chk({tag, "_dout"},     32'(sram_data_out), 32'd0);
        chk({tag, "_pix"},      32'({pix_data, pix_visible, pix_hsync, pix_vsync}), 32'd0);
        chk({tag, "_front"},    32'(front_sel), 32'd0);
        chk({tag, "_swapdone"}, 32'(swap_done), 32'd0);
        chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd0);
    endtask

    initial begin
        rd_tab[0] = '{10'd0,   10'd0,   20'd0};
        rd_tab[1] = '{10'd0,   10'd639, 20'd639};
        rd_tab[2] = '{10'd1,   10'd0,   20'd640};
        rd_tab[3] = '{10'd2,   10'd5,   20'd1285};
        rd_tab[4] = '{10'd479, 10'd639, 20'd307199};
        rd_tab[5] = '{10'd100, 10'd37,  20'd64037};
        wr_tab[0] = '{20'd0,      16'h1111, 20'd307200};
        wr_tab[1] = '{20'd307199, 16'h2222, 20'd614399};
        wr_tab[2] = '{20'd1000,   16'h3333, 20'd308200};

        reset = 1'b1;
        disp_visible = 0; disp_hsync = 0; disp_vsync = 0;
        disp_column = 0; disp_row = 0;
        wr_valid = 0; wr_addr = 0; wr_data = 0; swap_req = 0;
        din_ovr_en = 0; din_ovr = 0;
        #12;
        chk_reset_outputs("rst_init");
        step();
        reset = 1'b0;

        // Single read with returned word and sync alignment
        disp_visible = 1; disp_row = 10'd2; disp_column = 10'd5; disp_vsync = 1;
        step();
        chk("rd_addr", 32'(sram_addr), 32'd1285);
        chk("rd_oe_n", 32'(sram_oe_n), 32'd0);
        chk("rd_we_n", 32'(sram_we_n), 32'd1);
        chk("rd_data_oe", 32'(sram_data_oe), 32'd0);
        disp_visible = 0; disp_vsync = 0; din_ovr_en = 1; din_ovr = 16'hABCD;
        step();
        chk("rd_pix_data", 32'(pix_data), 32'hABCD);
        chk("rd_pix_syncs", 32'({pix_visible, pix_hsync, pix_vsync}), 32'b101);
        din_ovr_en = 0;
        step();
        chk("blank_pix_data", 32'(pix_data), 32'd0);
        chk("blank_pix_vis", 32'(pix_visible), 32'd0);

        // Back-to-back read addresses and pipelined data
        for (int i = 0; i < 6; i++) begin
            disp_visible = 1; disp_row = rd_tab[i].row; disp_column = rd_tab[i].col;
            step();
            chk("tab_rd_addr", 32'(sram_addr), 32'(rd_tab[i].exp_addr));
            chk("tab_rd_oe_n", 32'(sram_oe_n), 32'd0);
            if (i > 0) chk("tab_pix", 32'(pix_data),
                           32'(rd_tab[i-1].exp_addr[15:0] ^ 16'h5A5A));
        end
        disp_visible = 0;
        step();
        chk("tab_pix_last", 32'(pix_data), 32'(rd_tab[5].exp_addr[15:0] ^ 16'h5A5A));
        step();
        chk("tab_pix_blank", 32'(pix_data), 32'd0);

        // Writer held across the visible->blank edge
        disp_visible = 1; disp_row = 10'd3; disp_column = 10'd0;
        wr_valid = 1; wr_addr = 20'd7; wr_data = 16'h1234;
        #1 chk("edge_rdy_vis", 32'(wr_ready), 32'd0);
        step();
        disp_visible = 0;
        #1 chk("edge_rdy_after_rd", 32'(wr_ready), 32'd0);
        step();
        chk("edge_turn_strobes", 32'({sram_we_n, sram_oe_n, sram_data_oe}), 32'b110);
        chk("edge_rdy_turn", 32'(wr_ready), 32'd1);
        step();
        chk("edge_wr_we_n", 32'(sram_we_n), 32'd0);
        chk("edge_wr_oe", 32'({sram_oe_n, sram_data_oe}), 32'b11);
        chk("edge_wr_addr", 32'(sram_addr), 32'(FB + 7));
        chk("edge_wr_data", 32'(sram_data_out), 32'h1234);
        for (int i = 0; i < 3; i++) begin
            wr_addr = wr_tab[i].waddr; wr_data = wr_tab[i].wdata;
            step();
            chk("tab_wr_addr", 32'(sram_addr), 32'(wr_tab[i].exp_addr));
            chk("tab_wr_data", 32'(sram_data_out), 32'(wr_tab[i].wdata));
            chk("tab_wr_we_n", 32'(sram_we_n), 32'd0);
        end

        // Visible rises while the writer is busy: read follows with no gap
        disp_visible = 1; disp_row = 10'd0; disp_column = 10'd0; wr_addr = 20'd3;
        #1 chk("rise_rdy", 32'(wr_ready), 32'd0);
        step();
        chk("rise_rd_oe_n", 32'(sram_oe_n), 32'd0);
        chk("rise_rd_addr", 32'(sram_addr), 32'd0);
        disp_visible = 0;
        step();
        chk("rise_turn_we_n", 32'(sram_we_n), 32'd1);
        step();
        chk("rise_wr_addr", 32'(sram_addr), 32'(FB + 3));
        wr_valid = 0;
        step();
        chk("no_wr_after_rd", 32'(viol), 32'd0);

        // Two swap requests mid-frame -> a single swap at row 480 column 0
        chk("pre_swap_front", 32'(front_sel), 32'd0);
        disp_row = 10'd100; disp_column = 10'd20; swap_req = 1;
        step();
        swap_req = 0;
        step();
        swap_req = 1;
        step();
        chk("swap_early_done", 32'(swap_done), 32'd0);
        swap_req = 0; disp_row = 10'd480; disp_column = 10'd0;
        step();
        chk("swap_done", 32'(swap_done), 32'd1);
        chk("swap_front", 32'(front_sel), 32'd1);
        disp_column = 10'd1;
        step();
        chk("swap_done_pulse", 32'(swap_done), 32'd0);
        disp_column = 10'd0;
        step();
        chk("swap_absorbed", 32'({swap_done, front_sel}), 32'b01);
        disp_visible = 1; disp_row = 10'd2; disp_column = 10'd5;
        step();
        chk("swapped_rd_addr", 32'(sram_addr), 32'(FB + 1285));
        disp_visible = 0; wr_valid = 1; wr_addr = 20'd7; wr_data = 16'h7777;
        step();
        step();
        chk("swapped_wr_addr", 32'(sram_addr), 32'd7);
        chk("swapped_wr_we_n", 32'(sram_we_n), 32'd0);

        // Reset during a write, with a swap pending and pix_hsync high
        disp_row = 10'd10; wr_addr = 20'd5; wr_data = 16'h55AA;
        disp_hsync = 1; swap_req = 1;
        step();
        swap_req = 0;
        step();
        chk("pre_rst_we_n", 32'(sram_we_n), 32'd0);
        chk("pre_rst_hsync", 32'(pix_hsync), 32'd1);
        reset = 1;
        #1;
        chk_reset_outputs("rst_mid_wr");
        step();
        reset = 0; wr_valid = 0; disp_hsync = 0;
        disp_row = 10'd480; disp_column = 10'd0;
        step();
        chk("rst_clears_pending", 32'({swap_done, front_sel}), 32'b00);

        // Swap request on the swap point with a write accepted the same cycle
        disp_column = 10'd1;
        step();
        disp_column = 10'd0; swap_req = 1;
        wr_valid = 1; wr_addr = 20'd9; wr_data = 16'hBEEF;
        #1 chk("coinc_rdy", 32'(wr_ready), 32'd1);
        step();
        chk("coinc_swap", 32'({swap_done, front_sel}), 32'b11);
        chk("coinc_wr_addr", 32'(sram_addr), 32'(FB + 9));
        chk("coinc_wr_data", 32'(sram_data_out), 32'hBEEF);
        swap_req = 0; wr_valid = 0; disp_column = 10'd1;
        step();
        chk("coinc_done_pulse", 32'(swap_done), 32'd0);
        chk("final_no_wr_after_rd", 32'(viol), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
Name: vga_fb_arbiter

Overview:
- Shares one single-port async external SRAM between the VGA display read path and a pixel writer.
- The display side is driven by vga_sync outputs (visible, hsync, vsync, column, row). It returns pipelined pixel words with sync signals delayed to match.
- The writer fills the back buffer over a valid/ready handshake during blanking. Front/back buffers swap on request at a fixed frame point.

Parameters:
- ADDR_BITS, 20, SRAM word-address width.
- DATA_BITS, 16, SRAM data width.
- COLUMN_BITS, 10, width of disp_column.
- ROW_BITS, 10, width of disp_row.
- H_VISIBLE, 640, visible pixels per line.
- V_VISIBLE, 480, visible lines per frame.

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  asynchronous, active-high.
- disp_visible  in  1  from vga_sync.
- disp_hsync  in  1  from vga_sync.
- disp_vsync  in  1  from vga_sync.
- disp_column  in  COLUMN_BITS  from vga_sync.
- disp_row  in  ROW_BITS  from vga_sync.
- pix_data  out  DATA_BITS  pixel word read from the front buffer.
- pix_visible  out  1  disp_visible delayed 2 cycles.
- pix_hsync  out  1  disp_hsync delayed 2 cycles.
- pix_vsync  out  1  disp_vsync delayed 2 cycles.
- wr_valid  in  1  writer has a word.
- wr_ready  out  1  arbiter accepts the word this cycle.
- wr_addr  in  ADDR_BITS  back-buffer-relative address, 0..FB_WORDS-1.
- wr_data  in  DATA_BITS  write data.
- swap_req  in  1  single-cycle pulse requesting a front/back swap.
- swap_done  out  1  single-cycle pulse when the swap takes effect.
- front_sel  out  1  current front buffer index.
- sram_addr  out  ADDR_BITS  SRAM address.
- sram_data_out  out  DATA_BITS  SRAM write data.
- sram_data_in  in  DATA_BITS  SRAM read data.
- sram_data_oe  out  1  FPGA drives the SRAM data bus.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_oe_n  out  1  SRAM output enable, active low.

Behaviour:
- FB_WORDS = H_VISIBLE*V_VISIBLE.
- Buffer b occupies SRAM addresses b*FB_WORDS .. b*FB_WORDS+FB_WORDS-1.
- Bus FSM state is the registered op driven this cycle: IDLE, READ, TURN, WRITE.
- Next-op decision from cycle-t inputs, registered into cycle t+1, in priority order:
  1. disp_visible=1: READ. sram_addr = front_sel*FB_WORDS + disp_row*H_VISIBLE + disp_column, computed at ADDR_BITS width; oe_n=0, we_n=1, data_oe=0.
  2. Else, if wr_valid && wr_ready: WRITE. sram_addr = back base + wr_addr; sram_data_out = wr_data; data_oe=1, we_n=0, oe_n=1.
  3. Else, if wr_valid and state=READ: TURN. All strobes inactive, data_oe=0.
  4. Else: IDLE. All strobes inactive, data_oe=0.
- wr_ready = !disp_visible && state!=READ && !reset. It is combinational from the registered state.
  - A write never directly follows a read; at least one TURN/IDLE cycle is inserted for bus turnaround.
  - Write→read back-to-back is legal.
- Display has absolute priority. The writer never delays a read.
- Read pipeline:
  - Read is issued at t+1; sram_data_in is registered at the end of t+1; pix_data is valid at t+2.
  - Fixed latency is 2 cycles for pix_data and all three pix_* sync outputs.
  - pix_data is 0 when pix_visible=0.
- Swap:
  - swap_req sets swap_pending. A swap_req while pending is absorbed (one swap only).
  - The swap point is the cycle with disp_row==V_VISIBLE && disp_column==0.
  - At the swap point, if swap_pending or swap_req: front_sel toggles next cycle, swap_done pulses next cycle, and swap_pending clears.
  - The back base is sampled at write acceptance. A write accepted on the swap-point cycle targets the old back buffer.
- wr_addr ≥ FB_WORDS is unspecified (no check). The bench must not drive it.
- Reset, immediate on assertion:
  - State=IDLE, sram_we_n=1, sram_oe_n=1, sram_data_oe=0.
  - sram_addr=0, sram_data_out=0.
  - pix_*=0, front_sel=0, swap_pending=0, swap_done=0, wr_ready=0.
  - A write in flight is dropped: we_n is deasserted asynchronously.

Decomposition:
- Shared package vga_fb_pkg: bus_op_t enum (IDLE/READ/TURN/WRITE), FB_WORDS computation function, buffer-base function.
- One natural sub-module: vga_fb_delay. It is a parameterized N-stage shift register carrying {visible, hsync, vsync}, used for the 2-cycle sync alignment.

Test Plan:
- Reset mid-write: assert reset while state=WRITE → sram_we_n=1 and sram_data_oe=0 in the same cycle; all outputs at reset values.
- Visible line, front_sel=0, row=2, column=5 → sram_addr=1285 with oe_n=0 one cycle later. Return sram_data_in=16'hABCD → pix_data=16'hABCD two cycles after the input, with pix_visible=1.
- wr_valid held high across the visible→blank edge → wr_ready=0 while visible and on the cycle after the last read (TURN). First WRITE appears 2 cycles after visible falls, at addr FB_WORDS+wr_addr (front_sel=0).
- Writer active through blanking, then visible rises → the read is issued on the next cycle with no gap. No WRITE cycle ever immediately follows a READ cycle (checker over 3 frames).
- swap_req pulsed mid-frame, plus a second pulse → exactly one swap_done, in the cycle after row=480/column=0; front_sel 0→1. Subsequent reads base at 307200; writes base at 0.
- swap_req coincident with the swap point, plus a write accepted the same cycle → swap applied that frame; the write lands in the pre-swap back buffer.
